// File: rtl/ip_tile_scheduler_pkg.sv
// ip_tile_sched_pkg: shared state encoding and width constants for the tile scheduler
// Default bus MSB index, dimension width, and the one-bit-wider arithmetic width used for overflow-safe sums.
package ip_tile_sched_pkg;
  localparam int DEF_DATA_WIDTH = 15;
  localparam int DIM_W = DEF_DATA_WIDTH + 1;
  localparam int EXT_W = DEF_DATA_WIDTH + 2;
  typedef enum logic [2:0] {IDLE, SETUP, CLEAR, RUN, ADVANCE, FIN} state_t;
endpackage

// File: rtl/ip_tile_scheduler_if.sv
// ip_tile_scheduler_if: scheduler <-> address generator link
// master (scheduler): drives gen_rst, gen_enable, tile_ho/wo/th/tw, gen_C, tile_idx; receives stall, gen_done.
// slave (generator side): the mirror image.
interface ip_tile_scheduler_if import ip_tile_sched_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH);
  logic stall, gen_done, gen_rst, gen_enable;
  logic [DATA_WIDTH:0] tile_ho, tile_wo, tile_th, tile_tw, gen_C, tile_idx;
  modport master(input stall, gen_done, output gen_rst, gen_enable, tile_ho, tile_wo, tile_th, tile_tw, gen_C, tile_idx);
  modport slave(output stall, gen_done, input gen_rst, gen_enable, tile_ho, tile_wo, tile_th, tile_tw, gen_C, tile_idx);
endinterface

// File: rtl/ip_tile_scheduler_clip.sv
// ip_tile_clip: clipped tile extent min(t, d - o), computed one bit wider than the result
// Ports: t tile size, d map dimension, o tile origin (all W bits); m clipped extent (W-1 bits).
module ip_tile_clip #(parameter int W = 17) (
  input  logic [W-1:0] t,
  input  logic [W-1:0] d,
  input  logic [W-1:0] o,
  output logic [W-2:0] m
);
  logic [W-1:0] r;
  assign r = d - o;
  assign m = (t < r) ? t[W-2:0] : r[W-2:0];
endmodule

// File: rtl/ip_tile_scheduler.sv
// ip_tile_scheduler: walks an HxWxC map in Th x Tw tiles, sequencing the input-activation address generator
// Ports: clk, rst_n (async active-low); start, H, W, C, Th, Tw traversal request; gen (master modport) generator link;
// busy high during a traversal; done one-cycle completion pulse.
// Optional IP_TILE_SCHED_PERF_EN adds stall_cycles, a saturating count of stalled RUN cycles.
module ip_tile_scheduler import ip_tile_sched_pkg::*; #(parameter int DATA_WIDTH = DEF_DATA_WIDTH) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_WIDTH:0] H,
  input  logic [DATA_WIDTH:0] W,
  input  logic [DATA_WIDTH:0] C,
  input  logic [DATA_WIDTH:0] Th,
  input  logic [DATA_WIDTH:0] Tw,
  ip_tile_scheduler_if.master gen,
  output logic                busy,
  output logic                done
`ifdef IP_TILE_SCHED_PERF_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);
  localparam int EW = DATA_WIDTH + 2;
  state_t state;
  logic [DATA_WIDTH:0] h_q, w_q, th_q, tw_q, clip_h, clip_w;
  logic [EW-1:0] next_wo, next_ho;
  logic run, zero;
  assign zero = ~|H | ~|W | ~|C | ~|Th | ~|Tw;
  assign next_wo = {1'b0, gen.tile_wo} + {1'b0, tw_q};
  assign next_ho = {1'b0, gen.tile_ho} + {1'b0, th_q};
  assign gen.gen_enable = run & ~gen.stall;
  ip_tile_clip #(.W(EW)) u_clip_h (.t({1'b0, th_q}), .d({1'b0, h_q}), .o({1'b0, gen.tile_ho}), .m(clip_h));
  ip_tile_clip #(.W(EW)) u_clip_w (.t({1'b0, tw_q}), .d({1'b0, w_q}), .o({1'b0, gen.tile_wo}), .m(clip_w));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gen.gen_rst <= 1'b1;
      run <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      h_q <= '0;
      w_q <= '0;
      th_q <= '0;
      tw_q <= '0;
      gen.gen_C <= '0;
      gen.tile_ho <= '0;
      gen.tile_wo <= '0;
      gen.tile_th <= '0;
      gen.tile_tw <= '0;
      gen.tile_idx <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          h_q <= H;
          w_q <= W;
          th_q <= Th;
          tw_q <= Tw;
          gen.gen_C <= C;
          gen.tile_ho <= '0;
          gen.tile_wo <= '0;
          gen.tile_idx <= '0;
          busy <= ~zero;
          done <= zero;
          state <= zero ? FIN : SETUP;
        end
        SETUP: begin
          gen.tile_th <= clip_h;
          gen.tile_tw <= clip_w;
          state <= CLEAR;
        end
        CLEAR: begin
          gen.gen_rst <= 1'b0;
          run <= 1'b1;
          state <= RUN;
        end
        RUN: if (gen.gen_done) begin
          gen.gen_rst <= 1'b1;
          run <= 1'b0;
          state <= ADVANCE;
        end
        ADVANCE: begin
          gen.tile_idx <= gen.tile_idx + 1'b1;
          if (next_wo < {1'b0, w_q}) begin
            gen.tile_wo <= next_wo[DATA_WIDTH:0];
            state <= SETUP;
          end else begin
            gen.tile_wo <= '0;
            if (next_ho < {1'b0, h_q}) begin
              gen.tile_ho <= next_ho[DATA_WIDTH:0];
              state <= SETUP;
            end else begin
              busy <= 1'b0;
              done <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef IP_TILE_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (state == IDLE && start) stall_cycles <= '0;
    else if (state == RUN && gen.stall && ~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
  end
`endif
endmodule

// File: tb/tb_ip_tile_scheduler.sv
// tb_ip_tile_scheduler: directed and randomized traversals checked against a tile-list reference model
module tb_ip_tile_scheduler;
  localparam int DW = 15;
  localparam int N = DW + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [N-1:0] h_i = '0, w_i = '0, c_i = '0, th_i = '0, tw_i = '0;
  logic busy, done;
`ifdef IP_TILE_SCHED_PERF_EN
  logic [31:0] stall_cycles;
`endif
  int total = 0;
  int bad = 0;
  typedef struct {int ho; int wo; int th; int tw;} tile_t;
  ip_tile_scheduler_if #(.DATA_WIDTH(DW)) gif();
  ip_tile_scheduler #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .H(h_i), .W(w_i), .C(c_i), .Th(th_i), .Tw(tw_i),
    .gen(gif), .busy(busy), .done(done)
`ifdef IP_TILE_SCHED_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gen_rst"}, 64'(gif.gen_rst), 1);
    chk({tag, "_gen_enable"}, 64'(gif.gen_enable), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_tile"}, {gif.tile_ho, gif.tile_wo, gif.tile_th, gif.tile_tw}, 0);
    chk({tag, "_c_idx"}, {32'h0, gif.gen_C, gif.tile_idx}, 0);
  endtask
  task automatic traverse(input int h, w, c, th, tw, input int stall_tile, stall_len, input bit poke, input int abort_tile);
    tile_t q[$];
    int cyc;
    int exp_stall;
    for (int ho = 0; ho < h; ho += th)
      for (int wo = 0; wo < w; wo += tw)
        q.push_back('{ho, wo, (th < h - ho) ? th : h - ho, (tw < w - wo) ? tw : w - wo});
    exp_stall = (stall_tile >= 0 && stall_tile < q.size()) ? stall_len : 0;
    @(negedge clk);
    h_i = N'(h); w_i = N'(w); c_i = N'(c); th_i = N'(th); tw_i = N'(tw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 1);
    for (int k = 0; k < q.size(); k++) begin
      cyc = 1;
      while (gif.gen_rst !== 1'b0 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("latency_t%0d", k), 64'(cyc), (k == 0) ? 3 : 4);
      if (cyc >= 20) return;
      if (k == abort_tile) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk);
        chk("no_done_in_rst", 64'(done), 0);
        rst_n = 1'b1;
        return;
      end
      chk($sformatf("origin_t%0d", k), {gif.tile_ho, gif.tile_wo}, {N'(q[k].ho), N'(q[k].wo)});
      chk($sformatf("extent_t%0d", k), {gif.tile_th, gif.tile_tw}, {N'(q[k].th), N'(q[k].tw)});
      chk($sformatf("idx_c_t%0d", k), {gif.tile_idx, gif.gen_C}, {N'(k), N'(c)});
      chk($sformatf("run_flags_t%0d", k), {busy, gif.gen_enable, done}, 3'b110);
      if (poke && k == 0) begin
        start = 1'b1;
        h_i = 1; w_i = 1; th_i = 7;
        @(negedge clk);
        start = 1'b0;
      end
      if (k == stall_tile) begin
        for (int i = 0; i < stall_len; i++) begin
          gif.stall = 1'b1;
          #1 chk("stall_enable_low", 64'(gif.gen_enable), 0);
          @(negedge clk);
        end
        gif.stall = 1'b0;
        #1 chk("stall_release", 64'(gif.gen_enable), 1);
        @(negedge clk);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      gif.gen_done = 1'b1;
      @(negedge clk);
      gif.gen_done = 1'b0;
      chk($sformatf("advance_t%0d", k), {gif.gen_enable, gif.gen_rst}, 2'b01);
    end
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b10);
    @(negedge clk);
    chk("done_clear", {done, busy, gif.gen_rst}, 3'b001);
`ifdef IP_TILE_SCHED_PERF_EN
    chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
  endtask
  initial begin
    gif.stall = 1'b0;
    gif.gen_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    traverse(4, 4, 2, 2, 2, -1, 0, 1'b0, -1);
    traverse(5, 5, 3, 2, 2, -1, 0, 1'b0, -1);
    @(negedge clk);
    h_i = 4; w_i = 4; c_i = 2; th_i = 0; tw_i = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", {done, busy, gif.gen_rst}, 3'b101);
    @(negedge clk);
    chk("zero_after", {done, busy, gif.gen_rst}, 3'b001);
    traverse(4, 4, 2, 2, 2, 1, 10, 1'b0, -1);
    traverse(4, 4, 2, 2, 2, -1, 0, 1'b0, 2);
    traverse(4, 4, 2, 2, 2, -1, 0, 1'b0, -1);
    traverse(3, 7, 5, 2, 3, -1, 0, 1'b1, -1);
    for (int r = 0; r < 4; r++)
      traverse($urandom_range(1, 9), $urandom_range(1, 9), $urandom_range(1, 64), $urandom_range(1, 5), $urandom_range(1, 5),
               $urandom_range(0, 3), $urandom_range(1, 4), 1'b0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
